regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters: req0 is the ALU writeback and req1 is the load/multicycle unit.
- Includes a per-register pending scoreboard. Issue logic reserves destinations, and the block reports read-operand hazards for A1/A2.
- Sits between the execute/memory stages and the register file. Its rf_* outputs connect directly to WE3/A3/WD3.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 has a write
req0_addr  input  ADDR_W  requester 0 destination
req0_data  input  DATA_W  requester 0 data
req0_ready  output  1  requester 0 write accepted this cycle
req1_valid  input  1  requester 1 has a write
req1_addr  input  ADDR_W  requester 1 destination
req1_data  input  DATA_W  requester 1 data
req1_ready  output  1  requester 1 write accepted this cycle
rsv_valid  input  1  issue stage reserves a destination
rsv_addr  input  ADDR_W  destination being reserved
rd_a1  input  ADDR_W  read port 1 address (mirrors A1)
rd_a2  input  ADDR_W  read port 2 address (mirrors A2)
busy1  output  1  rd_a1 has a pending write
busy2  output  1  rd_a2 has a pending write
rsv_stall  output  1  rsv_addr already pending; issue must hold
rf_we  output  1  to WE3
rf_addr  output  ADDR_W  to A3
rf_wdata  output  DATA_W  to WD3

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_addr=0, rf_wdata=0.
  - RR pointer = 0 (req0 preferred).
  - All pending bits = 0.
  - Combinational outputs follow from the reset state.
- Arbitration (combinational):
  - Only one valid: that requester gets ready=1.
  - Both valid: the pointer side gets ready=1, the other gets 0.
  - ready never asserts without the matching valid. At most one ready per cycle.
- Pointer update: on any accept, pointer <= index of the requester not granted. Otherwise it holds.
- Requester rule: must hold valid/addr/data stable until ready. The output register always drains, so accept rate is one write per cycle.
- Write issue (1-cycle latency):
  - On the clock edge where reqN accepted: rf_addr<=reqN_addr, rf_wdata<=reqN_data, rf_we<=(reqN_addr!=0).
  - With no accept: rf_we<=0 and addr/data hold.
  - rf_we is high exactly one cycle per accepted non-x0 write.
  - Writes to x0 are accepted (ready=1) but never drive rf_we.
- Scoreboard (pending[2**ADDR_W], bit 0 hardwired 0):
  - Set: on an edge with rsv_valid=1, rsv_stall=0 and rsv_addr!=0.
  - Clear: on an edge with rf_we=1, for rf_addr. This is the same edge the register file commits.
  - Same address set and clear on one edge: set wins (new producer outstanding).
  - busy1=pending[rd_a1], busy2=pending[rd_a2], both combinational.
  - rsv_stall=rsv_valid & pending[rsv_addr]. Issue must not reserve an address that is already pending. No WAW counting.
  - A write to an unreserved address is legal and leaves pending at 0.
- Reset mid-operation: any in-flight rf_we is dropped immediately, and all pending bits clear asynchronously.

Test Plan:
1. Reset, then req0 valid addr=5 data=0xDEADBEEF at cycle 1 -> req0_ready=1 in cycle 1; cycle 2 rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF; cycle 3 rf_we=0.
2. req0 and req1 both valid for 4 cycles (addrs 1/2, stable, re-presented after each accept) -> grants 0,1,0,1; rf_addr sequence 1,2,1,2, one per cycle.
3. rsv addr=7 -> next cycle busy1=1 with rd_a1=7. req1 writes 7 -> busy1 drops the cycle after rf_we=1. A second rsv of 7 while pending -> rsv_stall=1 and no change.
4. req0 write addr=0 data=0x1234 -> req0_ready=1, rf_we stays 0. A rsv with addr=0 -> busy reads 0.
5. rf_we=1 for addr 9 while rsv_valid addr=9 on the same edge -> pending[9]=1 afterwards.
6. Assert rst low mid-stream with rf_we=1 and pending{3,4} set -> rf_we=0 immediately, busy outputs 0, pointer back to req0 after release.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester register-file write-port arbiter with pending scoreboard
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_a1,
    input  logic [ADDR_W-1:0] rd_a2,
    output logic              busy1,
    output logic              busy2,
    output logic              rsv_stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int NREG = 1 << ADDR_W;

    logic            ptr;
    logic            accept;
    logic            set_en;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // ptr=0 favours req0 when both requesters contend
    assign req0_ready = req0_valid & (~req1_valid | ~ptr);
    assign req1_ready = req1_valid & (~req0_valid | ptr);
    assign accept     = req0_ready | req1_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= req0_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else if (req0_ready) begin
            rf_we    <= (req0_addr != '0);
            rf_addr  <= req0_addr;
            rf_wdata <= req0_data;
        end else if (req1_ready) begin
            rf_we    <= (req1_addr != '0);
            rf_addr  <= req1_addr;
            rf_wdata <= req1_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign rsv_stall = rsv_valid & pending[rsv_addr];
    assign set_en    = rsv_valid & ~rsv_stall & (rsv_addr != '0);
    assign busy1     = pending[rd_a1];
    assign busy2     = pending[rd_a2];

    // Set is applied after clear so a fresh producer on the committing address stays outstanding
    always_comb begin
        pending_nxt = pending;
        if (rf_we) begin
            pending_nxt[rf_addr] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[rsv_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - scoreboard bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsv_valid = 1'b0;
    logic [4:0]  req0_addr = '0, req1_addr = '0, rsv_addr = '0, rd_a1 = '0, rd_a2 = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, busy1, busy2, rsv_stall, rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q[$];

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rd_a1(rd_a1), .rd_a2(rd_a2),
        .busy1(busy1), .busy2(busy2), .rsv_stall(rsv_stall),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Monitor: every committed write must match the oldest expected write
    always @(negedge clk) begin
        if (rst && rf_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write act=%0d:0x%0h exp=none", rf_addr, rf_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_addr, rf_wdata} !== e) begin
                    bad++;
                    $display("FAIL write act=%0d:0x%0h exp=%0d:0x%0h", rf_addr, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        step();
        settle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_busy", {busy1, busy2, rsv_stall}, 0);
        step();
        rst = 1'b1;

        // single req0 write
        step();
        req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        settle();
        chk("t1_ready", {req0_ready, req1_ready}, 2'b10);
        step();
        req0_valid = 0;
        settle();
        chk("t1_we", rf_we, 1);
        chk("t1_addr", rf_addr, 5);
        chk("t1_data", rf_wdata, 32'hDEADBEEF);
        step();
        settle();
        chk("t1_we_drop", rf_we, 0);

        // round-robin under contention
        do_reset();
        req0_valid = 1; req0_addr = 1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t2_ready", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i % 2 == 0) exp_q.push_back({5'd1, 32'h11});
            else            exp_q.push_back({5'd2, 32'h22});
            step();
        end
        req0_valid = 0; req1_valid = 0;
        settle();
        chk("t2_last_addr", rf_addr, 2);
        step();
        settle();
        chk("t2_we_drop", rf_we, 0);

        // reservation, stall on re-reserve, clear on commit
        step();
        rsv_valid = 1; rsv_addr = 7; rd_a1 = 7;
        settle();
        chk("t3_stall0", rsv_stall, 0);
        chk("t3_busy_pre", busy1, 0);
        step();
        settle();
        chk("t3_busy_set", busy1, 1);
        chk("t3_stall1", rsv_stall, 1);
        step();
        rsv_valid = 0;
        req1_valid = 1; req1_addr = 7; req1_data = 32'h77;
        exp_q.push_back({5'd7, 32'h77});
        settle();
        chk("t3_ready1", {req0_ready, req1_ready}, 2'b01);
        step();
        req1_valid = 0;
        settle();
        chk("t3_we", rf_we, 1);
        chk("t3_busy_hold", busy1, 1);
        step();
        settle();
        chk("t3_busy_clr", busy1, 0);

        // x0 write and x0 reservation
        step();
        req0_valid = 1; req0_addr = 0; req0_data = 32'h1234;
        settle();
        chk("t4_ready0", req0_ready, 1);
        step();
        req0_valid = 0;
        rsv_valid = 1; rsv_addr = 0; rd_a1 = 0; rd_a2 = 0;
        settle();
        chk("t4_we0", rf_we, 0);
        chk("t4_stall", rsv_stall, 0);
        step();
        rsv_valid = 0;
        settle();
        chk("t4_busy", {busy1, busy2}, 0);

        // set wins over clear on the same edge
        step();
        req0_valid = 1; req0_addr = 9; req0_data = 32'h99;
        exp_q.push_back({5'd9, 32'h99});
        step();
        req0_valid = 0;
        rsv_valid = 1; rsv_addr = 9; rd_a2 = 9;
        settle();
        chk("t5_we", rf_we, 1);
        chk("t5_stall", rsv_stall, 0);
        step();
        rsv_valid = 0;
        settle();
        chk("t5_busy2", busy2, 1);

        // reset mid-stream
        step();
        rsv_valid = 1; rsv_addr = 3;
        step();
        rsv_addr = 4;
        step();
        rsv_valid = 0; rd_a1 = 3; rd_a2 = 4;
        req0_valid = 1; req0_addr = 12; req0_data = 32'hC;
        settle();
        chk("t6_busy_set", {busy1, busy2}, 2'b11);
        step();
        req0_valid = 0;
        chk("t6_we_pre", rf_we, 1);
        rst = 0;
        #1;
        chk("t6_we_drop", rf_we, 0);
        chk("t6_busy_clr", {busy1, busy2}, 0);
        step();
        step();
        rst = 1;
        req0_valid = 1; req0_addr = 1; req0_data = 32'hA1;
        req1_valid = 1; req1_addr = 2; req1_data = 32'hB2;
        settle();
        chk("t6_ptr", {req0_ready, req1_ready}, 2'b10);
        exp_q.push_back({5'd1, 32'hA1});
        step();
        req0_valid = 0; req1_valid = 0;
        step();
        step();
        settle();
        chk("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
